nonzero_serializer: RTL and testbench

Downstream neighbour of `repetition_detector`: it consumes one group of `GROUP_SIZE` values plus the per-element zero-info mask, and emits only the non-zero elements, one per beat, each tagged with its in-group index. It supplies the zero-skipping datapath feeding the sparse compute stage. It also emits group and frame boundary flags so downstream counting stays aligned even when a group is entirely zero.

---
 rtl/nonzero_serializer_pkg.sv | 28 ++
 rtl/nonzero_serializer_lowest_set_encoder.sv | 28 ++
 rtl/nonzero_serializer.sv | 110 +++++++++++
 tb/tb_nonzero_serializer.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/nonzero_serializer_pkg.sv
// rtl/nonzero_serializer_pkg.sv - output field layout and index width shared with the sparse consumer
package nonzero_serializer_pkg;

  // Index field width for a group; a group of one or two elements still carries one index bit.
  function automatic int idx_width(input int group_size);
    return (group_size <= 2) ? 1 : $clog2(group_size);
  endfunction

  // data_out = {eof, empty, last, idx, value}, value at the bottom.
  localparam int VALUE_LSB = 0;

  function automatic int idx_lsb(input int data_width);
    return data_width;
  endfunction

  function automatic int last_bit(input int data_width, input int idx_w);
    return data_width + idx_w;
  endfunction

  function automatic int empty_bit(input int data_width, input int idx_w);
    return data_width + idx_w + 1;
  endfunction

  function automatic int eof_bit(input int data_width, input int idx_w);
    return data_width + idx_w + 2;
  endfunction

endpackage

// File: rtl/nonzero_serializer_lowest_set_encoder.sv
// rtl/nonzero_serializer_lowest_set_encoder.sv - lowest-set-bit priority encoder with one-hot and single_or_none
module lowest_set_encoder
  import nonzero_serializer_pkg::*;
#(
  parameter int GROUP_SIZE = 4,
  parameter int IDX_W      = idx_width(GROUP_SIZE)
) (
  input  logic [GROUP_SIZE-1:0] pending,
  output logic [IDX_W-1:0]      idx,
  output logic [GROUP_SIZE-1:0] onehot,
  output logic                  single_or_none
);

  // Scan from the top down so the lowest set bit wins; no bits set yields index 0.
  always_comb begin
    idx = '0;
    for (int i = GROUP_SIZE - 1; i >= 0; i--) begin
      if (pending[i]) idx = IDX_W'(i);
    end
  end

  // Two's-complement trick isolates the lowest set bit; clearing it leaves zero iff at most one bit was set.
  always_comb begin
    onehot         = pending & (~pending + GROUP_SIZE'(1));
    single_or_none = ((pending & (pending - GROUP_SIZE'(1))) == '0);
  end

endmodule

// File: rtl/nonzero_serializer.sv
// rtl/nonzero_serializer.sv - emits the non-zero elements of each group one per beat with group/frame flags
module nonzero_serializer
  import nonzero_serializer_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int GROUP_SIZE     = 4,
  parameter int ZERO_INFO      = GROUP_SIZE,
  parameter int IDX_W          = idx_width(GROUP_SIZE),
  parameter int LOG_MAX_GROUPS = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  configure,
  input  logic [LOG_MAX_GROUPS-1:0]             num_groups,
  input  logic [GROUP_SIZE*DATA_WIDTH+ZERO_INFO-1:0] data_in,
  input  logic                                  valid_in,
  output logic                                  avail_out,
  output logic [DATA_WIDTH+IDX_W+2:0]           data_out,
  output logic                                  valid_out,
  input  logic                                  avail_in
);

  localparam int OUT_W   = DATA_WIDTH + IDX_W + 3;
  localparam int IDX_LSB = idx_lsb(DATA_WIDTH);
  localparam int LAST_B  = last_bit(DATA_WIDTH, IDX_W);
  localparam int EMPTY_B = empty_bit(DATA_WIDTH, IDX_W);
  localparam int EOF_B   = eof_bit(DATA_WIDTH, IDX_W);

  logic [GROUP_SIZE*DATA_WIDTH-1:0] group_q;
  logic [GROUP_SIZE-1:0]            pending_q;
  logic                             full_q;
  logic [LOG_MAX_GROUPS-1:0]        grp_cnt_q;
  logic [LOG_MAX_GROUPS-1:0]        num_groups_q;

  logic [IDX_W-1:0]      enc_idx;
  logic [GROUP_SIZE-1:0] enc_onehot;
  logic                  last;
  logic                  empty;
  logic                  eof;
  logic [DATA_WIDTH-1:0] value;
  logic [OUT_W-1:0]      beat;
  logic                  accept;
  logic                  xfer;

  lowest_set_encoder #(
    .GROUP_SIZE(GROUP_SIZE),
    .IDX_W     (IDX_W)
  ) u_enc (
    .pending       (pending_q),
    .idx           (enc_idx),
    .onehot        (enc_onehot),
    .single_or_none(last)
  );

  // Select the element under the one-hot; an all-zero group selects nothing and yields value 0.
  always_comb begin
    value = '0;
    for (int i = 0; i < GROUP_SIZE; i++) begin
      if (enc_onehot[i]) value = group_q[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Assemble the current beat purely from held state; gate it to zero when nothing is being offered.
  always_comb begin
    empty            = (pending_q == '0);
    eof              = last & (grp_cnt_q == num_groups_q - LOG_MAX_GROUPS'(1));
    beat             = '0;
    beat[VALUE_LSB +: DATA_WIDTH] = value;
    beat[IDX_LSB +: IDX_W]        = enc_idx;
    beat[LAST_B]     = last;
    beat[EMPTY_B]    = empty;
    beat[EOF_B]      = eof;
    valid_out        = full_q & ~configure;
    data_out         = valid_out ? beat : '0;
    avail_out        = ~configure & (~full_q | (avail_in & last));
    accept           = valid_in & avail_out;
    xfer             = full_q & avail_in;
  end

  // Holding register, pending mask and frame counter; configure outranks transfer and accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      group_q      <= '0;
      pending_q    <= '0;
      full_q       <= 1'b0;
      grp_cnt_q    <= '0;
      num_groups_q <= LOG_MAX_GROUPS'(1);
    end else if (configure) begin
      pending_q    <= '0;
      full_q       <= 1'b0;
      grp_cnt_q    <= '0;
      num_groups_q <= (num_groups == '0) ? LOG_MAX_GROUPS'(1) : num_groups;
    end else begin
      if (xfer && !last) begin
        pending_q <= pending_q & ~enc_onehot;
      end
      if (xfer && last) begin
        full_q    <= 1'b0;
        grp_cnt_q <= eof ? '0 : grp_cnt_q + LOG_MAX_GROUPS'(1);
      end
      // A new group loaded on the same edge as a last transfer overrides the clear above.
      if (accept) begin
        group_q   <= data_in[GROUP_SIZE*DATA_WIDTH-1:0];
        pending_q <= ~data_in[GROUP_SIZE*DATA_WIDTH +: ZERO_INFO];
        full_q    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_nonzero_serializer.sv
// tb/tb_nonzero_serializer.sv - vector table plus randomized reference-model checks for nonzero_serializer
module tb_nonzero_serializer;

  logic        clk = 1'b0;
  logic        rst, configure, valid_in, avail_in;
  logic [15:0] num_groups;
  logic [35:0] data_in;
  logic        avail_out, valid_out;
  logic [12:0] data_out;

  int n_pass = 0;
  int n_total = 0;

  nonzero_serializer dut (
    .clk       (clk),
    .rst       (rst),
    .configure (configure),
    .num_groups(num_groups),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .avail_out (avail_out),
    .data_out  (data_out),
    .valid_out (valid_out),
    .avail_in  (avail_in)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        cfg;
    logic [15:0] ng;
    logic        vin;
    logic [35:0] din;
    logic        ain;
    logic        ev;
    logic [12:0] ed;
    logic        ea;
  } vec_t;

  typedef struct {
    bit       empty;
    bit       last;
    bit [1:0] idx;
    bit [7:0] val;
  } beat_t;

  vec_t  tbl[$];
  beat_t q[$];
  int    g;
  int    ngm;

  function automatic logic [35:0] mk(input logic [7:0] v3, v2, v1, v0, input logic [3:0] mask);
    return {mask, v3, v2, v1, v0};
  endfunction

  function automatic logic [12:0] bt(input logic eof, empty, last, input logic [1:0] idx, input logic [7:0] val);
    return {eof, empty, last, idx, val};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic row(input logic r, c, input logic [15:0] n, input logic v, input logic [35:0] d,
                     input logic a, input logic ev, input logic [12:0] ed, input logic ea);
    tbl.push_back('{rst: r, cfg: c, ng: n, vin: v, din: d, ain: a, ev: ev, ed: ed, ea: ea});
  endtask

  // Beats a group should produce: non-zero-by-mask elements in index order, or one empty beat.
  task automatic push_group(input logic [35:0] d);
    int n = 0;
    for (int i = 0; i < 4; i++) begin
      if (!d[32+i]) begin
        q.push_back('{empty: 1'b0, last: 1'b0, idx: 2'(i), val: d[i*8 +: 8]});
        n++;
      end
    end
    if (n == 0) q.push_back('{empty: 1'b1, last: 1'b1, idx: 2'd0, val: 8'd0});
    else q[q.size()-1].last = 1'b1;
  endtask

  initial begin
    logic [35:0] z4, a0, b0, c0, x0;
    logic        exp_valid, exp_avail;
    logic [12:0] exp_data;
    beat_t       b;

    z4 = mk(0, 0, 0, 0, 4'b1111);
    a0 = mk(4, 3, 2, 1, 4'b0000);
    b0 = mk(8, 7, 6, 5, 4'b0000);
    c0 = mk(3, 2, 1, 0, 4'b0001);
    x0 = mk(9, 9, 9, 9, 4'b0000);

    //  rst cfg ng vin din  ain ev ed                       ea
    row(0, 0, 0, 0, '0, 0, 0, '0, 1);                        // reset state
    row(0, 1, 2, 0, '0, 1, 0, '0, 0);                        // configure num_groups=2
    row(0, 0, 0, 1, c0, 1, 0, '0, 1);                        // accept {0,1,2,3} mask 0001
    row(0, 0, 0, 0, '0, 1, 1, bt(0, 0, 0, 1, 1), 0);
    row(0, 0, 0, 0, '0, 1, 1, bt(0, 0, 0, 2, 2), 0);
    row(0, 0, 0, 1, z4, 1, 1, bt(0, 0, 1, 3, 3), 1);         // last + accept all-zero group
    row(0, 0, 0, 0, '0, 1, 1, bt(1, 1, 1, 0, 0), 1);         // empty beat closes frame
    row(0, 0, 0, 1, a0, 1, 0, '0, 1);                        // back-to-back dense groups
    row(0, 0, 0, 1, b0, 1, 1, bt(0, 0, 0, 0, 1), 0);
    row(0, 0, 0, 1, b0, 1, 1, bt(0, 0, 0, 1, 2), 0);
    row(0, 0, 0, 1, b0, 1, 1, bt(0, 0, 0, 2, 3), 0);
    row(0, 0, 0, 1, b0, 1, 1, bt(0, 0, 1, 3, 4), 1);
    row(0, 0, 0, 0, '0, 1, 1, bt(0, 0, 0, 0, 5), 0);
    row(0, 0, 0, 1, x0, 0, 1, bt(0, 0, 0, 1, 6), 0);         // stall three cycles
    row(0, 0, 0, 1, x0, 0, 1, bt(0, 0, 0, 1, 6), 0);
    row(0, 0, 0, 1, x0, 0, 1, bt(0, 0, 0, 1, 6), 0);
    row(0, 0, 0, 0, '0, 1, 1, bt(0, 0, 0, 1, 6), 0);
    row(0, 0, 0, 0, '0, 1, 1, bt(0, 0, 0, 2, 7), 0);
    row(0, 0, 0, 0, '0, 1, 1, bt(1, 0, 1, 3, 8), 1);
    row(0, 0, 0, 1, a0, 1, 0, '0, 1);                        // half-emit then configure
    row(0, 0, 0, 0, '0, 1, 1, bt(0, 0, 0, 0, 1), 0);
    row(0, 0, 0, 0, '0, 1, 1, bt(0, 0, 0, 1, 2), 0);
    row(0, 1, 3, 0, '0, 1, 0, '0, 0);
    row(0, 0, 0, 1, z4, 1, 0, '0, 1);
    row(0, 0, 0, 1, z4, 1, 1, bt(0, 1, 1, 0, 0), 1);
    row(0, 0, 0, 1, z4, 1, 1, bt(0, 1, 1, 0, 0), 1);
    row(0, 0, 0, 0, '0, 1, 1, bt(1, 1, 1, 0, 0), 1);         // eof on third group
    row(0, 0, 0, 1, a0, 1, 0, '0, 1);                        // reset while full
    row(0, 0, 0, 0, '0, 1, 1, bt(0, 0, 0, 0, 1), 0);
    row(1, 0, 0, 0, '0, 1, 1, bt(0, 0, 0, 1, 2), 0);
    row(0, 0, 0, 0, '0, 1, 0, '0, 1);

    rst = 1'b1; configure = 1'b0; num_groups = '0; valid_in = 1'b0; data_in = '0; avail_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst; configure = tbl[i].cfg; num_groups = tbl[i].ng;
      valid_in = tbl[i].vin; data_in = tbl[i].din; avail_in = tbl[i].ain;
      #1;
      check($sformatf("row%0d valid_out", i), 32'(valid_out), 32'(tbl[i].ev));
      check($sformatf("row%0d data_out", i), 32'(data_out), 32'(tbl[i].ed));
      check($sformatf("row%0d avail_out", i), 32'(avail_out), 32'(tbl[i].ea));
      @(posedge clk);
      #1;
    end

    // Randomized run against the beat-queue model.
    g = 0; ngm = 1;
    for (int c = 0; c < 600; c++) begin
      rst        = ($urandom_range(0, 149) == 0);
      configure  = (c == 0) || (!rst && $urandom_range(0, 79) == 0);
      num_groups = 16'($urandom_range(0, 3));
      valid_in   = $urandom_range(0, 1);
      avail_in   = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++) begin
        data_in[i*8 +: 8] = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
        data_in[32+i]     = ($urandom_range(0, 1) == 0) ? (data_in[i*8 +: 8] == 0) : 1'($urandom_range(0, 1));
      end
      #1;
      exp_valid = !configure && (q.size() > 0);
      exp_data  = '0;
      if (exp_valid) exp_data = bt(q[0].last && (g == ngm - 1), q[0].empty, q[0].last, q[0].idx, q[0].val);
      exp_avail = !configure && (q.size() == 0 || (avail_in && q[0].last));
      check("rnd valid_out", 32'(valid_out), 32'(exp_valid));
      check("rnd data_out", 32'(data_out), 32'(exp_data));
      check("rnd avail_out", 32'(avail_out), 32'(exp_avail));
      if (rst) begin
        q.delete(); g = 0; ngm = 1;
      end else if (configure) begin
        q.delete(); g = 0; ngm = (num_groups == 0) ? 1 : int'(num_groups);
      end else begin
        if (q.size() > 0 && avail_in) begin
          b = q.pop_front();
          if (b.last) g = (g + 1) % ngm;
        end
        if (valid_in && exp_avail) push_group(data_in);
      end
      @(posedge clk);
      #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
